// File: rtl/store_commit_ctrl.sv
// store_commit_ctrl: commits the store at the ROB/LSQ heads to the data cache.
// Holds the retire stage while the write is in flight and releases it for one
// cycle once the cache accepts the write. Retries on an error or a timeout.
// After the retries run out, the block stays in a sticky fault state.
// Ports:
//   clk, reset (sync, active-low)
//   rob_head, lsq_head          - current ROB and LSQ head entries
//   retire_stall, store_done    - retire-stage control (combinational)
//   mem_req/addr/wdata/size     - data-cache write request
//   mem_ack, mem_err            - cache accept, qualified by the error flag
//   fault                       - sticky; retries are exhausted
//   stores_committed            - saturating count of completed stores
//   stall_cycles                - saturating count of stalled cycles

package store_commit_pkg;
    localparam int unsigned TAG_W   = 6;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WORD_W  = 64;
    localparam int unsigned MTYPE_W = 4;
    localparam int unsigned ALUOP_W = 4;

    typedef logic [ADDR_W-1:0]  Address;
    typedef logic [WORD_W-1:0]  MemoryWord;
    typedef logic [MTYPE_W-1:0] mem_type_t;

    localparam mem_type_t MT_NONE = 4'd0;
    localparam mem_type_t MT_LB   = 4'd1;
    localparam mem_type_t MT_LH   = 4'd2;
    localparam mem_type_t MT_LW   = 4'd3;
    localparam mem_type_t MT_LD   = 4'd4;
    localparam mem_type_t MT_SB   = 4'd8;
    localparam mem_type_t MT_SH   = 4'd9;
    localparam mem_type_t MT_SW   = 4'd10;
    localparam mem_type_t MT_SD   = 4'd11;

    typedef struct packed {
        mem_type_t          memory_type;
        logic               regwr;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_bits_t;

    typedef struct packed {
        logic             ready;
        logic [TAG_W-1:0] tag;
        ctrl_bits_t       ctrl_bits;
    } rob_entry;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        Address           address;
        MemoryWord        value;
    } lsq_entry;
endpackage

module store_commit_ctrl
    import store_commit_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  rob_entry    rob_head,
    input  lsq_entry    lsq_head,
    output logic        retire_stall,
    output logic        store_done,
    output logic        mem_req,
    output Address      mem_addr,
    output MemoryWord   mem_wdata,
    output logic [3:0]  mem_size,
    input  logic        mem_ack,
    input  logic        mem_err,
    output logic        fault,
    output logic [31:0] stores_committed,
    output logic [31:0] stall_cycles
);

    localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_BACKOFF = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [TIMER_W-1:0] timer;
    logic [RETRY_W-1:0] retry;
    logic               st_hit;
    logic [3:0]         size_c;
    logic               latch_en;
    logic               timer_inc;
    logic               retry_inc;
    logic               count_inc;

    // Fields of the ROB head that this block has no use for.
    logic unused_ctrl;
    assign unused_ctrl = ^{rob_head.ctrl_bits.regwr, rob_head.ctrl_bits.alu_op};

    // Store type decode; zero marks a non-store.
    always_comb begin
        size_c = 4'd0;
        case (rob_head.ctrl_bits.memory_type)
            MT_SB:   size_c = 4'd1;
            MT_SH:   size_c = 4'd2;
            MT_SW:   size_c = 4'd4;
            MT_SD:   size_c = 4'd8;
            default: size_c = 4'd0;
        endcase
    end

    assign st_hit = rob_head.ready && (rob_head.tag == lsq_head.tag) && (size_c != 4'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, retire/memory handshake and datapath enables.
    always_comb begin
        state_next   = state;
        retire_stall = 1'b0;
        store_done   = 1'b0;
        mem_req      = 1'b0;
        latch_en     = 1'b0;
        timer_inc    = 1'b0;
        retry_inc    = 1'b0;
        count_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                retire_stall = st_hit;
                if (st_hit) begin
                    latch_en   = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                mem_req      = 1'b1;
                retire_stall = 1'b1;
                // An ack beats a coincident timeout.
                if (mem_ack && !mem_err) begin
                    state_next = S_DONE;
                end else if (mem_ack || (timer == TIMER_LAST)) begin
                    state_next = (32'(retry) < MAX_RETRY) ? S_BACKOFF : S_FAULT;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_BACKOFF: begin
                retire_stall = 1'b1;
                retry_inc    = 1'b1;
                state_next   = S_REQ;
            end
            S_DONE: begin
                store_done = 1'b1;
                count_inc  = 1'b1;
                state_next = S_IDLE;
            end
            S_FAULT: begin
                retire_stall = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request payload, timer/retry bookkeeping, fault flag and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_size         <= 4'd0;
            timer            <= '0;
            retry            <= '0;
            fault            <= 1'b0;
            stores_committed <= 32'd0;
            stall_cycles     <= 32'd0;
        end else begin
            if (latch_en) begin
                mem_addr  <= lsq_head.address;
                mem_wdata <= lsq_head.value;
                mem_size  <= size_c;
                timer     <= '0;
                retry     <= '0;
            end else if (retry_inc) begin
                retry <= retry + RETRY_W'(1);
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + TIMER_W'(1);
            end
            // FAULT only ever loops to itself, so this is sticky until reset.
            fault <= (state_next == S_FAULT);
            if (count_inc && (stores_committed != CNT_MAX)) begin
                stores_committed <= stores_committed + 32'd1;
            end
            if (retire_stall && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_store_commit_ctrl.sv
// Bench for store_commit_ctrl: directed scenarios plus randomized traffic.
// All outputs are compared every cycle against a transaction-level model.
module tb_store_commit_ctrl;
    import store_commit_pkg::*;

    localparam int unsigned TIMEOUT   = 8;
    localparam int unsigned MAX_RETRY = 1;

    logic        clk = 1'b0;
    logic        reset;
    rob_entry    rob_head;
    lsq_entry    lsq_head;
    logic        retire_stall, store_done, mem_req, mem_ack, mem_err, fault;
    Address      mem_addr;
    MemoryWord   mem_wdata;
    logic [3:0]  mem_size;
    logic [31:0] stores_committed, stall_cycles;

    always #5 clk = ~clk;

    store_commit_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset(reset), .rob_head(rob_head), .lsq_head(lsq_head),
        .retire_stall(retire_stall), .store_done(store_done), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_ack(mem_ack), .mem_err(mem_err), .fault(fault),
        .stores_committed(stores_committed), .stall_cycles(stall_cycles)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: one store in flight at a time, tracked by its own bookkeeping.
    bit          m_busy, m_pause, m_finish, m_dead;
    int          m_wait, m_tries;
    logic [31:0] m_addr;
    logic [63:0] m_data;
    logic [3:0]  m_size;
    logic [31:0] m_count, m_stall;

    // Values observed at the last sample point.
    logic o_done, o_fault, o_req, o_stall;
    logic [31:0] o_count, o_stallcnt;
    logic [3:0]  o_size;

    function automatic int size_of(input mem_type_t t);
        case (t)
            MT_SB:   return 1;
            MT_SH:   return 2;
            MT_SW:   return 4;
            MT_SD:   return 8;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_pause = 0; m_finish = 0; m_dead = 0;
        m_wait = 0; m_tries = 0;
        m_addr = '0; m_data = '0; m_size = '0; m_count = '0; m_stall = '0;
    endtask

    function automatic bit requesting();
        return m_busy && !m_pause && !m_finish && !m_dead;
    endfunction

    // One clock: check all outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit hit, es, ed, er;
        @(negedge clk);
        hit = rob_head.ready && (rob_head.tag == lsq_head.tag)
              && (size_of(rob_head.ctrl_bits.memory_type) != 0);
        if (m_dead)        begin es = 1; ed = 0; er = 0; end
        else if (m_finish) begin es = 0; ed = 1; er = 0; end
        else if (m_pause)  begin es = 1; ed = 0; er = 0; end
        else if (m_busy)   begin es = 1; ed = 0; er = 1; end
        else               begin es = hit; ed = 0; er = 0; end
        check_eq("retire_stall", 64'(retire_stall), 64'(es));
        check_eq("store_done", 64'(store_done), 64'(ed));
        check_eq("mem_req", 64'(mem_req), 64'(er));
        check_eq("fault", 64'(fault), 64'(m_dead));
        check_eq("mem_addr", 64'(mem_addr), 64'(m_addr));
        check_eq("mem_wdata", mem_wdata, m_data);
        check_eq("mem_size", 64'(mem_size), 64'(m_size));
        check_eq("stores_committed", 64'(stores_committed), 64'(m_count));
        check_eq("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        o_done = store_done; o_fault = fault; o_req = mem_req; o_stall = retire_stall;
        o_count = stores_committed; o_stallcnt = stall_cycles; o_size = mem_size;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (es && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (m_dead) begin
            end else if (m_finish) begin
                m_finish = 0; m_busy = 0;
                if (m_count != 32'hFFFF_FFFF) m_count++;
            end else if (m_pause) begin
                m_pause = 0; m_wait = 0;
            end else if (m_busy) begin
                if (mem_ack && !mem_err) m_finish = 1;
                else if (mem_ack || m_wait == int'(TIMEOUT) - 1) begin
                    if (m_tries < int'(MAX_RETRY)) begin m_tries++; m_pause = 1; end
                    else m_dead = 1;
                end else m_wait++;
            end else if (hit) begin
                m_busy = 1; m_wait = 0; m_tries = 0;
                m_addr = lsq_head.address; m_data = lsq_head.value;
                m_size = 4'(size_of(rob_head.ctrl_bits.memory_type));
            end
        end
        #1;
    endtask

    task automatic set_head(input bit rdy, input mem_type_t mt, input bit match,
                            input logic [31:0] a, input logic [63:0] v);
        rob_head.ready = rdy;
        rob_head.tag = TAG_W'($urandom);
        rob_head.ctrl_bits.memory_type = mt;
        rob_head.ctrl_bits.regwr = (size_of(mt) == 0);
        rob_head.ctrl_bits.alu_op = ALUOP_W'($urandom);
        lsq_head.tag = match ? rob_head.tag : (rob_head.tag ^ TAG_W'(1));
        lsq_head.address = a;
        lsq_head.value = v;
    endtask

    task automatic set_nonstore();
        set_head(1'b1, MT_NONE, 1'b1, $urandom, {$urandom, $urandom});
    endtask

    // Ack policy driven from the model; stray acks when no request is expected.
    task automatic drive_ack(input int ack_at, input bit err_first);
        if (requesting()) begin
            mem_ack = (ack_at >= 0) && (m_wait == ack_at);
            mem_err = mem_ack && err_first && (m_tries == 0);
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
            mem_err = 1'($urandom_range(0, 1));
        end
    endtask

    // Present one store and run until the DUT pulses store_done (bounded).
    task automatic run_store(input mem_type_t mt, input logic [31:0] a, input logic [63:0] v,
                             input int ack_at, input bit err_first, output int lat,
                             output logic [3:0] size_at_done);
        lat = -1;
        size_at_done = 4'hF;
        set_head(1'b1, mt, 1'b1, a, v);
        for (int c = 0; c < 100; c++) begin
            drive_ack(ack_at, err_first);
            cycle();
            if (o_done) begin lat = c; size_at_done = o_size; break; end
        end
        set_nonstore();
        mem_ack = 0; mem_err = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        cycle();
        reset = 1;
    endtask

    int lat;
    logic [3:0] sz;
    int first_fault;

    initial begin
        reset = 0; mem_ack = 0; mem_err = 0;
        set_nonstore();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1;

        // Reset state and non-store heads passing through.
        cycle();
        check_eq("rst_stall_cnt", 64'(o_stallcnt), 64'd0);
        for (int i = 0; i < 10; i++) begin
            set_nonstore();
            mem_ack = 1'($urandom_range(0, 1));
            cycle();
        end
        mem_ack = 0;
        check_eq("alu_committed", 64'(o_count), 64'd0);

        // SW with immediate ack.
        do_reset();
        run_store(MT_SW, 32'h1000, 64'hDEAD_BEEF, 0, 1'b0, lat, sz);
        check_eq("sw_latency", 64'(lat), 64'd2);
        check_eq("sw_size", 64'(sz), 64'd4);
        cycle();
        check_eq("sw_committed", 64'(o_count), 64'd1);
        check_eq("sw_stall_cnt", 64'(o_stallcnt), 64'd2);
        check_eq("sw_idle_gap", 64'(o_stall), 64'd0);

        // SD acked on the sixth request cycle.
        do_reset();
        run_store(MT_SD, 32'h2468_ACE0, 64'h0123_4567_89AB_CDEF, 5, 1'b0, lat, sz);
        check_eq("sd_latency", 64'(lat), 64'd7);
        check_eq("sd_size", 64'(sz), 64'd8);

        // Error on first attempt, then a clean ack: one backoff.
        do_reset();
        run_store(MT_SH, 32'h0000_0042, 64'h0000_0000_0000_BEEF, 0, 1'b1, lat, sz);
        check_eq("err_latency", 64'(lat), 64'd4);
        cycle();
        check_eq("err_committed", 64'(o_count), 64'd1);

        // No ack ever: REQ x TIMEOUT, BACKOFF, REQ x TIMEOUT, FAULT.
        do_reset();
        set_head(1'b1, MT_SB, 1'b1, 32'hCAFE_0001, 64'h55);
        first_fault = -1;
        for (int c = 0; c < 40; c++) begin
            drive_ack(-1, 1'b0);
            cycle();
            if (o_fault && first_fault < 0) first_fault = c;
        end
        check_eq("fault_cycle", 64'(first_fault), 64'(2 * TIMEOUT + 2));
        check_eq("fault_sticky", 64'(o_fault), 64'd1);
        check_eq("fault_stall", 64'(o_stall), 64'd1);
        set_nonstore();
        mem_ack = 0;
        do_reset();
        cycle();
        check_eq("fault_cleared", 64'(o_fault), 64'd0);
        check_eq("fault_rst_cnt", 64'(o_stallcnt), 64'd0);

        // Reset in the middle of a request aborts it.
        set_head(1'b1, MT_SW, 1'b1, 32'h0000_3000, 64'h1111_2222);
        mem_ack = 0;
        for (int c = 0; c < 4; c++) cycle();
        check_eq("abort_req_pre", 64'(o_req), 64'd1);
        reset = 0;
        cycle();
        reset = 1;
        set_nonstore();
        cycle();
        check_eq("abort_req", 64'(o_req), 64'd0);
        check_eq("abort_committed", 64'(o_count), 64'd0);
        check_eq("abort_stall_cnt", 64'(o_stallcnt), 64'd0);
        run_store(MT_SW, 32'h0000_3000, 64'h1111_2222, 0, 1'b0, lat, sz);
        check_eq("abort_retry_lat", 64'(lat), 64'd2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (!m_busy) begin
                case ($urandom_range(0, 4))
                    0, 1: set_head(1'b1, mem_type_t'($urandom_range(8, 11)), 1'b1, $urandom, {$urandom, $urandom});
                    2: set_head(1'b1, mem_type_t'($urandom_range(8, 11)), 1'b0, $urandom, {$urandom, $urandom});
                    3: set_head(1'b0, mem_type_t'($urandom_range(8, 11)), 1'b1, $urandom, {$urandom, $urandom});
                    default: set_head(1'b1, mem_type_t'($urandom_range(0, 4)), 1'b1, $urandom, {$urandom, $urandom});
                endcase
            end
            mem_ack = ($urandom_range(0, 9) < 3);
            mem_err = ($urandom_range(0, 9) < 2);
            reset = ($urandom_range(0, 99) != 0);
            cycle();
        end
        reset = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
